bcd2bin: RTL
============

BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 SHALL provide parameter NDIG, default 3, meaning the number of packed BCD input digits.
REQ-002 SHALL provide parameter BIN_W, default 10, meaning the binary output width; legal only when 2^BIN_W >= 10^NDIG.
REQ-003 SHALL provide port clk  input  1  sole clock, rising edge active.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port in_valid  input  1  bcd_in is valid this cycle.
REQ-006 SHALL provide port in_ready  output  1  block can accept an input this cycle.
REQ-007 SHALL provide port bcd_in  input  4*NDIG  packed BCD, digit 0 (units) in bits [3:0].
REQ-008 SHALL provide port out_valid  output  1  bin_out and err are valid.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts the result this cycle.
REQ-010 SHALL provide port bin_out  output  BIN_W  unsigned binary value of the accepted BCD word.
REQ-011 SHALL provide port err  output  1  accepted word contained a digit > 9.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; in_ready SHALL be a registered or pure state decode, never combinationally dependent on in_valid.
REQ-014 SHALL accept the input on a rising edge where in_valid=1 and in_ready=1, and latch bcd_in into an internal shift register.
REQ-015 SHALL, on acceptance, check every digit; if any digit > 9 it SHALL go directly to DONE with err=1 and bin_out=0.
REQ-016 SHALL, on acceptance of an all-valid word, go to CONV, clear the binary accumulator, and load an iteration counter with BIN_W.
REQ-017 SHALL, each CONV cycle, shift the concatenation {BCD register, binary accumulator} right by one bit, then subtract 3 from each BCD digit whose post-shift value is >= 8.
REQ-018 SHALL decrement the iteration counter each CONV cycle and move to DONE on the edge that performs iteration BIN_W.
REQ-019 SHALL raise out_valid exactly BIN_W rising edges after the accepting edge for a valid word, and exactly 1 edge after it for an invalid word.
REQ-020 SHALL hold out_valid, bin_out and err stable in DONE until a rising edge where out_ready=1, then return to IDLE with out_valid=0.
REQ-021 SHALL NOT accept a new input on the same edge that the result is consumed; the earliest next acceptance is one cycle after the DONE->IDLE transition.
REQ-022 SHALL ignore in_valid and bcd_in changes while in CONV or DONE.
REQ-023 SHALL keep out_valid=0 in IDLE and CONV; bin_out and err SHALL be don't-care when out_valid=0, except at reset.
REQ-024 SHALL produce bin_out equal to the decimal value of bcd_in for every all-valid input, including 0 and 10^NDIG-1.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, counter=0, and clear all shift registers.
REQ-026 SHALL abandon any in-progress conversion or undelivered result when rst_n asserts, with no output handshake for it.
REQ-027 SHALL resume normal operation on the first rising edge after rst_n deasserts, accepting input on that edge if in_valid=1.

Verification
REQ-028 SHALL cover: bcd_in=0x000 accepted, out_ready=1 -> out_valid at accept+10 edges, bin_out=0, err=0, one-cycle pulse.
REQ-029 SHALL cover: bcd_in=0x999 -> bin_out=999 (0x3E7), err=0; then bcd_in=0x255 -> bin_out=255 (0x0FF).
REQ-030 SHALL cover: bcd_in=0x1A3 -> out_valid one edge after acceptance with err=1 and bin_out=0.
REQ-031 SHALL cover: bcd_in=0x128 with out_ready=0 for 5 cycles after out_valid -> out_valid, bin_out=128 and in_ready=0 held stable; release 1 cycle -> IDLE.
REQ-032 SHALL cover: rst_n pulsed low at the 4th CONV cycle of bcd_in=0x777 -> outputs at reset values immediately; a following bcd_in=0x042 -> bin_out=42.
REQ-033 SHALL cover: exhaustive sweep 0x000-0x999 of all-valid words against a decimal reference model, with random in_valid/out_ready throttling.

Source files
------------

// File: rtl/bcd2bin.sv
// ---------------------------------------------------------------------------
// bcd2bin -- sequential packed-BCD to unsigned binary converter.
//
// Converts an NDIG-digit packed BCD word to binary with the reverse
// double-dabble algorithm. Each iteration shifts {bcd, acc} right by one bit
// and then subtracts 3 from every BCD digit that reads >= 8. After BIN_W
// iterations the accumulator holds the binary value.
//
// Words that contain a digit > 9 are flagged with err=1 and bin_out=0. That
// result appears one edge after acceptance.
//
// Ports
//   clk        sole clock, rising edge active
//   rst_n      asynchronous active-low reset
//   in_valid   bcd_in is valid this cycle
//   in_ready   block can accept an input this cycle (IDLE only)
//   bcd_in     packed BCD, digit 0 (units) in bits [3:0]
//   out_valid  bin_out and err are valid
//   out_ready  consumer accepts the result this cycle
//   bin_out    unsigned binary value of the accepted word
//   err        accepted word contained a digit > 9
// ---------------------------------------------------------------------------
module bcd2bin #(
    parameter int NDIG  = 3,
    parameter int BIN_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [BCD_W-1:0]   bcd_r;
    logic [BIN_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               bad_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [BIN_W-1:0]   bin_out_r;
    logic               err_r;

    logic [BCD_W-1:0]   bcd_sh_s;
    logic [BCD_W-1:0]   bcd_fix_s;
    logic [BIN_W-1:0]   acc_sh_s;
    logic               last_s;

    // Returns 1 when any BCD digit of the word is outside 0..9.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (word[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    assign last_s    = (cnt_r == CNT_W'(1));
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign bin_out   = bin_out_r;
    assign err       = err_r;

    // One conversion step: shift right, then correct digits that read >= 8.
    always_comb begin
        {bcd_sh_s, acc_sh_s} = {bcd_r, acc_r} >> 1'b1;
        bcd_fix_s = bcd_sh_s;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_sh_s[4*i +: 4] >= 4'd8) begin
                bcd_fix_s[4*i +: 4] = bcd_sh_s[4*i +: 4] - 4'd3;
            end else begin
                bcd_fix_s[4*i +: 4] = bcd_sh_s[4*i +: 4];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CONV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, iteration counter and registered outputs.
    // A bad word still passes through CONV, but only for a single cycle.
    // That cycle makes its result show up one edge after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r       <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            bad_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            bin_out_r   <= '0;
            err_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        bcd_r <= bcd_in;
                        acc_r <= '0;
                        bad_r <= has_bad_digit(bcd_in);
                        if (has_bad_digit(bcd_in)) begin
                            cnt_r <= CNT_W'(1);
                        end else begin
                            cnt_r <= CNT_W'(BIN_W);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                CONV: begin
                    bcd_r <= bcd_fix_s;
                    acc_r <= acc_sh_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_s) begin
                        bin_out_r <= bad_r ? '0 : acc_sh_s;
                        err_r     <= bad_r;
                    end else begin
                        err_r     <= err_r;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule
